// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer: ISA opcodes,
// controller states, decoded instruction classes, write-data selects and field positions.
package seq_pkg;

  typedef enum logic [2:0] {
    OP_STORE = 3'b000,
    OP_LOAD  = 3'b001,
    OP_ADD   = 3'b010,
    OP_BEQ   = 3'b101,
    OP_STOP  = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEMWB  = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  // Opcode 001 splits on bit 12, so the decoder reports a class rather than a raw opcode.
  typedef enum logic [2:0] {
    CLS_NOP     = 3'd0,
    CLS_STORE   = 3'd1,
    CLS_LDI     = 3'd2,
    CLS_LDM     = 3'd3,
    CLS_ADD     = 3'd4,
    CLS_BEQ     = 3'd5,
    CLS_STOP    = 3'd6,
    CLS_ILLEGAL = 3'd7
  } instr_class_e;

  localparam logic [1:0] WSEL_IMM = 2'd0;
  localparam logic [1:0] WSEL_DM  = 2'd1;
  localparam logic [1:0] WSEL_ADD = 2'd2;

  localparam int OPC_LSB = 13;
  localparam int LDI_BIT = 12;
  localparam int TGT_LSB = 8;
  localparam int RD_LSB  = 8;
  localparam int RA_LSB  = 4;
  localparam int RB_LSB  = 0;
  localparam int IMM_LSB = 0;

endpackage

// File: rtl/instr_decoder.sv
// Combinational field decode of the latched instruction word: class, register and
// memory addresses, immediate, write-data select and branch target.
module instr_decoder
  import seq_pkg::*;
(
  input  logic [15:0] ir_i,
  output logic [2:0]  cls_o,
  output logic [3:0]  ra_a_o,
  output logic [3:0]  ra_b_o,
  output logic [3:0]  wa_o,
  output logic [3:0]  dm_addr_o,
  output logic [7:0]  imm_o,
  output logic [1:0]  wsel_o,
  output logic [4:0]  target_o
);

  instr_class_e cls_s;

  always_comb begin
    cls_s = CLS_NOP;
    case (ir_i[OPC_LSB +: 3])
      OP_STORE: cls_s = CLS_STORE;
      OP_LOAD:  cls_s = ir_i[LDI_BIT] ? CLS_LDI : CLS_LDM;
      OP_ADD:   cls_s = CLS_ADD;
      OP_BEQ:   cls_s = CLS_BEQ;
      OP_STOP:  cls_s = CLS_STOP;
      default:  cls_s = CLS_ILLEGAL;
    endcase
  end

  always_comb begin
    wsel_o = WSEL_IMM;
    case (cls_s)
      CLS_LDI: wsel_o = WSEL_IMM;
      CLS_LDM: wsel_o = WSEL_DM;
      CLS_ADD: wsel_o = WSEL_ADD;
      default: wsel_o = WSEL_IMM;
    endcase
  end

  // Store reads its data register from the low nibble; load-memory writes to it.
  assign cls_o     = cls_s;
  assign ra_a_o    = (cls_s == CLS_STORE) ? ir_i[RB_LSB +: 4] : ir_i[RA_LSB +: 4];
  assign ra_b_o    = ir_i[RB_LSB +: 4];
  assign wa_o      = (cls_s == CLS_LDM) ? ir_i[RB_LSB +: 4] : ir_i[RD_LSB +: 4];
  assign dm_addr_o = ir_i[RA_LSB +: 4];
  assign imm_o     = ir_i[IMM_LSB +: 8];
  assign target_o  = ir_i[TGT_LSB +: 5];

endmodule

// File: rtl/instruction_sequencer.sv
// Fetch/decode/execute controller for the 32 x 16-bit instruction memory.
// Define ILLEGAL_OP_TRAP_EN to halt with trap=1 on opcodes 011/100/110 (otherwise NOPs).
module instruction_sequencer
  import seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] instr,
  output logic [4:0]  pc,
  output logic [3:0]  rf_ra_a,
  output logic [3:0]  rf_ra_b,
  input  logic [15:0] rf_rd_a,
  input  logic [15:0] rf_rd_b,
  output logic        rf_we,
  output logic [3:0]  rf_wa,
  output logic [1:0]  rf_wsel,
  output logic [7:0]  imm,
  output logic        dm_we,
  output logic [3:0]  dm_addr,
  output logic        busy,
  output logic        halted
`ifdef ILLEGAL_OP_TRAP_EN
  ,
  output logic        trap
`endif
);

  state_e      state_q, state_d;
  logic [4:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        rf_we_q, rf_we_d;
  logic        dm_we_q, dm_we_d;
  logic [3:0]  rf_wa_q, rf_wa_d;
  logic [3:0]  rf_ra_a_q, rf_ra_a_d;
  logic [3:0]  rf_ra_b_q, rf_ra_b_d;
  logic [3:0]  dm_addr_q, dm_addr_d;
  logic [7:0]  imm_q, imm_d;
  logic [1:0]  rf_wsel_q, rf_wsel_d;
  logic        busy_q, busy_d;
  logic        halted_q, halted_d;
`ifdef ILLEGAL_OP_TRAP_EN
  logic        trap_q, trap_d;
`endif

  logic [2:0]  dec_cls_s;
  logic [3:0]  dec_ra_a_s, dec_ra_b_s, dec_wa_s, dec_dm_addr_s;
  logic [7:0]  dec_imm_s;
  logic [1:0]  dec_wsel_s;
  logic [4:0]  dec_target_s;
  logic [4:0]  pc_inc_s;

  instr_decoder u_dec (
    .ir_i      (ir_q),
    .cls_o     (dec_cls_s),
    .ra_a_o    (dec_ra_a_s),
    .ra_b_o    (dec_ra_b_s),
    .wa_o      (dec_wa_s),
    .dm_addr_o (dec_dm_addr_s),
    .imm_o     (dec_imm_s),
    .wsel_o    (dec_wsel_s),
    .target_o  (dec_target_s)
  );

  assign pc_inc_s = pc_q + 5'd1;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    rf_we_d   = 1'b0;
    dm_we_d   = 1'b0;
    rf_wa_d   = rf_wa_q;
    rf_ra_a_d = rf_ra_a_q;
    rf_ra_b_d = rf_ra_b_q;
    dm_addr_d = dm_addr_q;
    imm_d     = imm_q;
    rf_wsel_d = rf_wsel_q;
`ifdef ILLEGAL_OP_TRAP_EN
    trap_d    = trap_q;
`endif
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = 5'd0;
`ifdef ILLEGAL_OP_TRAP_EN
          trap_d  = 1'b0;
`endif
        end else begin
          state_d = state_q;
        end
      end
      S_FETCH: begin
        ir_d    = instr;
        state_d = S_DECODE;
      end
      // Strobes are registered here so they are high exactly during EXEC.
      S_DECODE: begin
        rf_ra_a_d = dec_ra_a_s;
        rf_ra_b_d = dec_ra_b_s;
        dm_addr_d = dec_dm_addr_s;
        rf_wa_d   = dec_wa_s;
        imm_d     = dec_imm_s;
        rf_wsel_d = dec_wsel_s;
        rf_we_d   = (dec_cls_s == CLS_LDI) || (dec_cls_s == CLS_ADD);
        dm_we_d   = (dec_cls_s == CLS_STORE);
        state_d   = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_inc_s;
        case (dec_cls_s)
          CLS_LDM: begin
            state_d = S_MEMWB;
            pc_d    = pc_q;
            rf_we_d = 1'b1;
          end
          CLS_STOP: begin
            state_d = S_HALT;
            pc_d    = pc_q;
          end
          CLS_BEQ: begin
            if (rf_rd_a == rf_rd_b) begin
              pc_d = dec_target_s;
            end else begin
              pc_d = pc_inc_s;
            end
          end
          CLS_ILLEGAL: begin
`ifdef ILLEGAL_OP_TRAP_EN
            state_d = S_HALT;
            pc_d    = pc_q;
            trap_d  = 1'b1;
`else
            pc_d    = pc_inc_s;
`endif
          end
          default: pc_d = pc_inc_s;
        endcase
      end
      S_MEMWB: begin
        state_d = S_FETCH;
        pc_d    = pc_inc_s;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d   = (state_d != S_IDLE) && (state_d != S_HALT);
    halted_d = (state_d == S_HALT);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= 5'd0;
      ir_q      <= 16'd0;
      rf_we_q   <= 1'b0;
      dm_we_q   <= 1'b0;
      rf_wa_q   <= 4'd0;
      rf_ra_a_q <= 4'd0;
      rf_ra_b_q <= 4'd0;
      dm_addr_q <= 4'd0;
      imm_q     <= 8'd0;
      rf_wsel_q <= 2'd0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
      trap_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      rf_we_q   <= rf_we_d;
      dm_we_q   <= dm_we_d;
      rf_wa_q   <= rf_wa_d;
      rf_ra_a_q <= rf_ra_a_d;
      rf_ra_b_q <= rf_ra_b_d;
      dm_addr_q <= dm_addr_d;
      imm_q     <= imm_d;
      rf_wsel_q <= rf_wsel_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
`ifdef ILLEGAL_OP_TRAP_EN
      trap_q    <= trap_d;
`endif
    end
  end

  // A reset arriving during EXEC/MEMWB suppresses the strobe in that same cycle.
  assign rf_we   = rf_we_q & ~reset;
  assign dm_we   = dm_we_q & ~reset;
  assign pc      = pc_q;
  assign rf_ra_a = rf_ra_a_q;
  assign rf_ra_b = rf_ra_b_q;
  assign rf_wa   = rf_wa_q;
  assign rf_wsel = rf_wsel_q;
  assign imm     = imm_q;
  assign dm_addr = dm_addr_q;
  assign busy    = busy_q;
  assign halted  = halted_q;
`ifdef ILLEGAL_OP_TRAP_EN
  assign trap    = trap_q;
`endif

endmodule
